crc_a_ctrl: RTL and testbench

Sequencer that owns a single `crc_a` instance and shares it between the receive path (CRC check) and the transmit path (CRC generation/append) of the ISO/IEC 14443-3A PICC. On RX it drives `crc_a` from the bit-level receive interface and reports pass/fail at end of frame. On TX it passes the payload bit stream through while feeding `crc_a`, then appends the 16 CRC bits LSByte first, LSb first. It sits between the bit-level framing layer and the byte/frame layers; parity insertion happens downstream.

---
 rtl/crc_a_ctrl_pkg.sv | 25 ++
 rtl/crc_a_ctrl_if.sv | 43 ++++
 rtl/crc_a_ctrl_crc_a.sv | 29 ++
 rtl/crc_a_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_crc_a_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/crc_a_ctrl_pkg.sv
// crc_a_ctrl_pkg: shared types and constants for the CRC_A sequencer.
// The optional RX error counter is enabled by defining CRC_A_CTRL_ERR_CNT_EN.
package crc_a_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX      = 2'd1,
    ST_TX_DATA = 2'd2,
    ST_TX_CRC  = 2'd3
  } crc_a_ctrl_state_e;

  localparam logic [15:0] CRC_A_PRESET    = 16'h6363;
  // x^16 + x^12 + x^5 + 1, bit-reversed because data arrives LSb first
  localparam logic [15:0] CRC_A_POLY_REFL = 16'h8408;
  localparam int          CRC_BITS        = 16;
  localparam int          MIN_RX_BITS     = 16;

  // One bit-serial step of the reflected CRC_A register.
  function automatic logic [15:0] crc_a_step(input logic [15:0] crc, input logic d);
    logic fb;
    fb = crc[0] ^ d;
    crc_a_step = (crc >> 1) ^ (fb ? CRC_A_POLY_REFL : 16'h0000);
  endfunction

endpackage

// File: rtl/crc_a_ctrl_if.sv
// crc_a_ctrl_if: RX bit interface and TX bit streams of the CRC_A sequencer.
//
// Handshake rule for both TX streams: a bit transfers on a rising clock edge
// exactly when valid and ready are both high; valid and data from the source
// stay stable while ready is low, and ready may toggle freely.
interface crc_a_ctrl_if;
  // RX side
  logic       rx_soc;
  logic       rx_eoc;
  logic       rx_data;
  logic       rx_data_valid;
  logic       rx_crc_valid;
  logic       rx_crc_ok;
  logic       rx_dropped;
  logic [7:0] rx_err_count;
  // TX side
  logic       tx_req;
  logic       tx_gnt;
  logic       tx_in_data;
  logic       tx_in_valid;
  logic       tx_in_last;
  logic       tx_in_ready;
  logic       tx_out_data;
  logic       tx_out_valid;
  logic       tx_out_last;
  logic       tx_out_ready;

  // Framing layer side: drives frames in, consumes verdicts and TX output
  modport master (
    output rx_soc, rx_eoc, rx_data, rx_data_valid,
    input  rx_crc_valid, rx_crc_ok, rx_dropped, rx_err_count,
    output tx_req, tx_in_data, tx_in_valid, tx_in_last, tx_out_ready,
    input  tx_gnt, tx_in_ready, tx_out_data, tx_out_valid, tx_out_last
  );

  // Sequencer side
  modport slave (
    input  rx_soc, rx_eoc, rx_data, rx_data_valid,
    output rx_crc_valid, rx_crc_ok, rx_dropped, rx_err_count,
    input  tx_req, tx_in_data, tx_in_valid, tx_in_last, tx_out_ready,
    output tx_gnt, tx_in_ready, tx_out_data, tx_out_valid, tx_out_last
  );
endinterface

// File: rtl/crc_a_ctrl_crc_a.sv
// crc_a: bit-serial ISO/IEC 14443-3A CRC register (preset 0x6363, LSb first).
// start reloads the preset and takes priority over sample.
module crc_a
  import crc_a_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_sample,
  input  logic        i_data,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // CRC register: preset on reset/start, shift one bit per sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= CRC_A_PRESET;
    end else if (i_start) begin
      r_crc <= CRC_A_PRESET;
    end else if (i_sample) begin
      r_crc <= crc_a_step(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc_a_ctrl.sv
// crc_a_ctrl: shares one crc_a between RX check and TX generate/append.
// Optional feature macro: CRC_A_CTRL_ERR_CNT_EN (saturating RX CRC error count).
module crc_a_ctrl
  import crc_a_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  crc_a_ctrl_if.slave       bus,
  output crc_a_ctrl_state_e o_dbg_state
);

  crc_a_ctrl_state_e r_state;
  crc_a_ctrl_state_e w_state_nxt;

  logic        w_rst_n;
  logic        w_crc_start;
  logic        w_crc_sample;
  logic        w_crc_data;
  logic [15:0] w_crc;

  logic        w_rx_done;
  logic        w_rx_ok;
  logic        w_drop;

  logic [4:0]  r_bit_cnt;
  logic [3:0]  r_idx;
  logic        r_rx_valid;
  logic        r_rx_ok;
  logic        r_rx_dropped;

  logic        w_tx_in_ready;
  logic        w_tx_out_valid;
  logic        w_tx_out_data;
  logic        w_tx_out_last;

  assign w_rst_n = !rst;

  crc_a u_crc_a (
    .i_clk    (clk),
    .i_rst_n  (w_rst_n),
    .i_start  (w_crc_start),
    .i_sample (w_crc_sample),
    .i_data   (w_crc_data),
    .o_crc    (w_crc)
  );

  // Verdict is valid only when the residue is zero and enough bits arrived
  assign w_rx_ok = (w_crc == 16'h0000) && (r_bit_cnt >= 5'(MIN_RX_BITS));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, crc_a control and stream outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_crc_start    = 1'b0;
    w_crc_sample   = 1'b0;
    w_crc_data     = 1'b0;
    w_rx_done      = 1'b0;
    w_drop         = 1'b0;
    w_tx_in_ready  = 1'b0;
    w_tx_out_valid = 1'b0;
    w_tx_out_data  = 1'b0;
    w_tx_out_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // RX wins a tie; tx_req is a level so TX stays pending
        if (bus.rx_soc) begin
          w_state_nxt = ST_RX;
          w_crc_start = 1'b1;
        end else if (bus.tx_req) begin
          w_state_nxt = ST_TX_DATA;
          w_crc_start = 1'b1;
        end
      end
      ST_RX: begin
        w_crc_sample = bus.rx_data_valid;
        w_crc_data   = bus.rx_data;
        if (bus.rx_soc) begin
          w_crc_start = 1'b1;
        end else if (bus.rx_eoc) begin
          w_state_nxt = ST_IDLE;
          w_rx_done   = 1'b1;
        end
      end
      ST_TX_DATA: begin
        w_tx_in_ready  = bus.tx_out_ready;
        w_tx_out_valid = bus.tx_in_valid;
        w_tx_out_data  = bus.tx_in_data;
        w_crc_sample   = bus.tx_in_valid & bus.tx_out_ready;
        w_crc_data     = bus.tx_in_data;
        w_drop         = bus.rx_soc;
        if (bus.tx_in_valid && bus.tx_out_ready && bus.tx_in_last) begin
          w_state_nxt = ST_TX_CRC;
        end
      end
      ST_TX_CRC: begin
        // No samples here, so the CRC register itself holds the value to send
        w_tx_out_valid = 1'b1;
        w_tx_out_data  = w_crc[r_idx];
        w_tx_out_last  = (r_idx == 4'(CRC_BITS - 1));
        w_drop         = bus.rx_soc;
        if (bus.tx_out_ready && (r_idx == 4'(CRC_BITS - 1))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // RX bit counter: cleared on every frame start, saturates at MIN_RX_BITS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= 5'd0;
    end else if (w_crc_start) begin
      r_bit_cnt <= 5'd0;
    end else if ((r_state == ST_RX) && bus.rx_data_valid &&
                 (r_bit_cnt < 5'(MIN_RX_BITS))) begin
      r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  // CRC append index: advances per accepted CRC bit, wraps to 0 after bit 15
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 4'd0;
    end else if (r_state != ST_TX_CRC) begin
      r_idx <= 4'd0;
    end else if (bus.tx_out_ready) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  // RX verdict pulse and held result, plus the dropped-SOC pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_valid   <= 1'b0;
      r_rx_ok      <= 1'b0;
      r_rx_dropped <= 1'b0;
    end else begin
      r_rx_valid   <= w_rx_done;
      r_rx_dropped <= w_drop;
      if (w_rx_done) begin
        r_rx_ok <= w_rx_ok;
      end
    end
  end

`ifdef CRC_A_CTRL_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Failure count updates together with the verdict it counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_rx_done && !w_rx_ok && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.rx_err_count = r_err_cnt;
`else
  assign bus.rx_err_count = 8'd0;
`endif

  assign bus.rx_crc_valid = r_rx_valid;
  assign bus.rx_crc_ok    = r_rx_ok;
  assign bus.rx_dropped   = r_rx_dropped;
  assign bus.tx_gnt       = (r_state == ST_TX_DATA) || (r_state == ST_TX_CRC);
  assign bus.tx_in_ready  = w_tx_in_ready;
  assign bus.tx_out_valid = w_tx_out_valid;
  assign bus.tx_out_data  = w_tx_out_data;
  assign bus.tx_out_last  = w_tx_out_last;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_crc_a_ctrl.sv
// tb_crc_a_ctrl: directed test of the CRC_A sequencer.
module tb_crc_a_ctrl;
  import crc_a_ctrl_pkg::*;

  logic clk;
  logic rst;
  crc_a_ctrl_state_e dbg_state;

  int total;
  int bad;

  crc_a_ctrl_if u_if ();

  crc_a_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (u_if.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CRC_A_CTRL_ERR_CNT_EN
  localparam logic [7:0] E1 = 8'd1;
  localparam logic [7:0] E2 = 8'd2;
`else
  localparam logic [7:0] E1 = 8'd0;
  localparam logic [7:0] E2 = 8'd0;
`endif

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_crc_valid"}, 16'(u_if.rx_crc_valid), 16'h0);
    check({tag, "_crc_ok"},    16'(u_if.rx_crc_ok),    16'h0);
    check({tag, "_dropped"},   16'(u_if.rx_dropped),   16'h0);
    check({tag, "_err_cnt"},   16'(u_if.rx_err_count), 16'h0);
    check({tag, "_gnt"},       16'(u_if.tx_gnt),       16'h0);
    check({tag, "_in_ready"},  16'(u_if.tx_in_ready),  16'h0);
    check({tag, "_out_valid"}, 16'(u_if.tx_out_valid), 16'h0);
    check({tag, "_out_last"},  16'(u_if.tx_out_last),  16'h0);
    check({tag, "_state"},     16'(dbg_state),         16'(ST_IDLE));
  endtask

  // driver: one RX frame, called and returning at a falling edge
  task automatic rx_run(input string tag, input logic [31:0] bits, input int nbits,
                        input logic exp_ok, input logic [7:0] exp_cnt);
    u_if.rx_soc = 1'b1;
    @(negedge clk);
    u_if.rx_soc = 1'b0;
    check({tag, "_state_rx"}, 16'(dbg_state), 16'(ST_RX));
    check({tag, "_gnt_rx"}, 16'(u_if.tx_gnt), 16'h0);
    for (int i = 0; i < nbits; i++) begin
      u_if.rx_data_valid = 1'b1;
      u_if.rx_data       = bits[i];
      @(negedge clk);
    end
    u_if.rx_data_valid = 1'b0;
    u_if.rx_data       = 1'b0;
    u_if.rx_eoc        = 1'b1;
    @(negedge clk);
    u_if.rx_eoc = 1'b0;
    check({tag, "_valid"}, 16'(u_if.rx_crc_valid), 16'h1);
    check({tag, "_ok"},    16'(u_if.rx_crc_ok),    16'(exp_ok));
    check({tag, "_cnt"},   16'(u_if.rx_err_count), 16'(exp_cnt));
    check({tag, "_gnt_verdict"}, 16'(u_if.tx_gnt), 16'h0);
    @(negedge clk);
    check({tag, "_valid_pulse"}, 16'(u_if.rx_crc_valid), 16'h0);
    check({tag, "_ok_held"},     16'(u_if.rx_crc_ok),    16'(exp_ok));
  endtask

  // driver + scoreboard: one TX frame of two payload bytes
  task automatic tx_run(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [15:0] crc_exp, input int stall_pct,
                        input int soc_at, input int rst_at);
    logic [0:0]  exp_q[$];
    logic [15:0] pay;
    logic [0:0]  exp_bit;
    int n_hs, pay_idx, cyc;
    bit drop_pending, soc_done, rst_hit;
    pay = {b1, b0};
    for (int i = 0; i < 16; i++) exp_q.push_back(pay[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(crc_exp[i]);
    n_hs = 0; pay_idx = 0; cyc = 0;
    drop_pending = 0; soc_done = 0; rst_hit = 0;
    u_if.tx_req = 1'b1;
    while (n_hs < 32 && cyc < 3000 && !rst_hit) begin
      if (u_if.tx_gnt) u_if.tx_req = 1'b0;
      u_if.tx_in_valid  = (pay_idx < 16);
      u_if.tx_in_data   = (pay_idx < 16) ? pay[pay_idx[3:0]] : 1'b0;
      u_if.tx_in_last   = (pay_idx == 15);
      u_if.tx_out_ready = ($urandom_range(0, 99) >= stall_pct);
      if (n_hs == soc_at && u_if.tx_gnt && !soc_done) begin
        u_if.rx_soc  = 1'b1;
        drop_pending = 1;
        soc_done     = 1;
      end
      #1;
      if (n_hs == rst_at) begin
        rst = 1'b1;
        #1;
        check_idle_outputs({tag, "_async_rst"});
        rst_hit = 1;
      end else if (u_if.tx_out_valid && u_if.tx_out_ready) begin
        exp_bit = exp_q.pop_front();
        check($sformatf("%s_bit%0d", tag, n_hs), 16'(u_if.tx_out_data), 16'(exp_bit));
        check($sformatf("%s_last%0d", tag, n_hs), 16'(u_if.tx_out_last), 16'(n_hs == 31));
        if (n_hs < 16) pay_idx++;
        n_hs++;
      end
      @(negedge clk);
      cyc++;
      u_if.rx_soc = 1'b0;
      if (drop_pending) begin
        check({tag, "_dropped"}, 16'(u_if.rx_dropped), 16'h1);
        drop_pending = 0;
      end
    end
    u_if.tx_in_valid  = 1'b0;
    u_if.tx_in_data   = 1'b0;
    u_if.tx_in_last   = 1'b0;
    u_if.tx_out_ready = 1'b0;
    u_if.tx_req       = 1'b0;
    if (!rst_hit) begin
      check({tag, "_timeout"}, 16'(cyc < 3000), 16'h1);
      check({tag, "_soc_done"}, 16'(soc_done), 16'(soc_at >= 0));
      check({tag, "_end_state"}, 16'(dbg_state), 16'(ST_IDLE));
      check({tag, "_end_gnt"}, 16'(u_if.tx_gnt), 16'h0);
      check({tag, "_end_valid"}, 16'(u_if.tx_out_valid), 16'h0);
    end
  endtask

  // directed sequence
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    u_if.rx_soc = 1'b0; u_if.rx_eoc = 1'b0;
    u_if.rx_data = 1'b0; u_if.rx_data_valid = 1'b0;
    u_if.tx_req = 1'b0; u_if.tx_in_data = 1'b0;
    u_if.tx_in_valid = 1'b0; u_if.tx_in_last = 1'b0;
    u_if.tx_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // good frame 00 00 A0 1E, corrupted A1, and a frame too short
    rx_run("rx_good",  32'h1EA0_0000, 32, 1'b1, 8'd0);
    rx_run("rx_bad",   32'h1EA1_0000, 32, 1'b0, E1);
    rx_run("rx_short", 32'h0000_0000, 8,  1'b0, E2);

    // TX 12 34 with stalls appends 26 CF
    tx_run("tx_1234", 8'h12, 8'h34, 16'hCF26, 40, -1, -1);

    // simultaneous rx_soc and tx_req: RX first, then TX with a dropped soc
    u_if.tx_req = 1'b1;
    rx_run("rx_tie", 32'h1EA0_0000, 32, 1'b1, E2);
    check("tie_gnt_after_verdict", 16'(u_if.tx_gnt), 16'h1);
    tx_run("tx_tie", 8'h12, 8'h34, 16'hCF26, 30, 5, -1);

    // reset during CRC append at idx 7, then a clean 00 00 frame
    tx_run("tx_rst", 8'h12, 8'h34, 16'hCF26, 0, -1, 23);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_rst");
    tx_run("tx_0000", 8'h00, 8'h00, 16'h1EA0, 25, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
